letc_core_limp_arbiter: RTL and testbench

- Shares the single AXI FSM LIMP port between the instruction cache (port 0) and the data cache (port 1).
- Sits between the two `letc_core_cache` instances and the AXI FSM.
- Registered round-robin grant with a per-owner quantum, so a cache line refill can stream back-to-back without being interleaved, while neither side starves.

---
 rtl/letc_core_pkg.sv | 22 ++
 rtl/letc_core_limp_if.sv | 24 ++
 rtl/letc_core_limp_arbiter.sv | 143 ++++++++++++++
 tb/tb_letc_core_limp_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/letc_core_pkg.sv
// Shared LETC core types: LIMP payload types and the LIMP arbiter state encoding.
package letc_core_pkg;

  localparam int PADDR_W = 32;
  localparam int WORD_W  = 32;

  typedef logic [PADDR_W-1:0] paddr_t;
  typedef logic [WORD_W-1:0]  word_t;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALFWORD = 2'b01,
    SIZE_WORD     = 2'b10
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } limp_arb_state_e;

endpackage

// File: rtl/letc_core_limp_if.sv
// LIMP valid/ready request channel between a cache (requestor) and its servicer.
interface letc_core_limp_if;
  import letc_core_pkg::*;

  logic   valid;
  logic   ready;
  logic   wen_nren;
  logic   uncacheable;
  size_e  size;
  paddr_t addr;
  word_t  wdata;
  word_t  rdata;

  modport requestor (
    output valid, wen_nren, uncacheable, size, addr, wdata,
    input  ready, rdata
  );

  modport servicer (
    input  valid, wen_nren, uncacheable, size, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/letc_core_limp_arbiter.sv
// Round-robin arbiter sharing the AXI FSM LIMP port between icache (0) and dcache (1),
// with a per-owner quantum so line refills stream without interleaving.
module letc_core_limp_arbiter
  import letc_core_pkg::*;
#(
  parameter int QUANTUM = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  letc_core_limp_if.servicer icache_limp,
  letc_core_limp_if.servicer dcache_limp,
  letc_core_limp_if.requestor axi_fsm_limp,
  output logic              o_owner,
  output logic              o_busy
);

  localparam int                CNT_W     = $clog2(QUANTUM + 1);
  localparam logic [CNT_W-1:0]  QUANT_CNT = CNT_W'(QUANTUM);
  localparam logic [CNT_W:0]    QUANT_EXT = (CNT_W + 1)'(QUANTUM);

  limp_arb_state_e  state, state_n;
  logic             prio, prio_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic owner;
  logic own_valid;
  logic oth_valid;
  logic hs;
  logic quantum_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == QUANT_CNT) ? c : c + 1'b1;
  endfunction

  function automatic limp_arb_state_e grant_of(input logic port);
    return port ? GRANT_D : GRANT_I;
  endfunction

  // Next-state: decisions depend on downstream ready, but downstream valid never does.
  always_comb begin
    state_n      = state;
    prio_n       = prio;
    cnt_n        = cnt;
    owner        = (state == GRANT_D);
    own_valid    = owner ? dcache_limp.valid : icache_limp.valid;
    oth_valid    = owner ? icache_limp.valid : dcache_limp.valid;
    hs           = 1'b0;
    quantum_done = 1'b0;

    unique case (state)
      IDLE: begin
        if (icache_limp.valid && dcache_limp.valid) begin
          state_n = grant_of(prio);
          cnt_n   = '0;
        end else if (icache_limp.valid) begin
          state_n = GRANT_I;
          cnt_n   = '0;
        end else if (dcache_limp.valid) begin
          state_n = GRANT_D;
          cnt_n   = '0;
        end
      end

      GRANT_I, GRANT_D: begin
        hs           = own_valid && axi_fsm_limp.ready;
        quantum_done = ({1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1}) >= QUANT_EXT;
        if (hs && quantum_done && oth_valid) begin
          state_n = grant_of(~owner);
          prio_n  = ~owner;
          cnt_n   = '0;
        end else if (!own_valid && oth_valid) begin
          state_n = grant_of(~owner);
          prio_n  = ~owner;
          cnt_n   = '0;
        end else if (!own_valid) begin
          state_n = IDLE;
          prio_n  = ~owner;
        end else if (hs) begin
          cnt_n = sat_inc(cnt);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      prio  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_n;
      prio  <= prio_n;
      cnt   <= cnt_n;
    end
  end

  // Payload mux: the owner sees the downstream port, the non-owner sees all zeros.
  always_comb begin
    axi_fsm_limp.valid       = 1'b0;
    axi_fsm_limp.wen_nren    = 1'b0;
    axi_fsm_limp.uncacheable = 1'b0;
    axi_fsm_limp.size        = SIZE_BYTE;
    axi_fsm_limp.addr        = '0;
    axi_fsm_limp.wdata       = '0;
    icache_limp.ready        = 1'b0;
    icache_limp.rdata        = '0;
    dcache_limp.ready        = 1'b0;
    dcache_limp.rdata        = '0;

    unique case (state)
      GRANT_I: begin
        axi_fsm_limp.valid       = icache_limp.valid;
        axi_fsm_limp.wen_nren    = icache_limp.wen_nren;
        axi_fsm_limp.uncacheable = icache_limp.uncacheable;
        axi_fsm_limp.size        = icache_limp.size;
        axi_fsm_limp.addr        = icache_limp.addr;
        axi_fsm_limp.wdata       = icache_limp.wdata;
        icache_limp.ready        = axi_fsm_limp.ready;
        icache_limp.rdata        = axi_fsm_limp.rdata;
      end
      GRANT_D: begin
        axi_fsm_limp.valid       = dcache_limp.valid;
        axi_fsm_limp.wen_nren    = dcache_limp.wen_nren;
        axi_fsm_limp.uncacheable = dcache_limp.uncacheable;
        axi_fsm_limp.size        = dcache_limp.size;
        axi_fsm_limp.addr        = dcache_limp.addr;
        axi_fsm_limp.wdata       = dcache_limp.wdata;
        dcache_limp.ready        = axi_fsm_limp.ready;
        dcache_limp.rdata        = axi_fsm_limp.rdata;
      end
      default: begin
      end
    endcase
  end

  assign o_busy  = (state != IDLE);
  assign o_owner = (state == GRANT_D);

endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// Scoreboard bench for letc_core_limp_arbiter: requester tasks queue expected
// transfers and grant order; a negedge monitor pops and compares on each handshake.
module tb_letc_core_limp_arbiter;
  import letc_core_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic owner;
  logic busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  logic owner_q[$];

  letc_core_limp_if icache_limp ();
  letc_core_limp_if dcache_limp ();
  letc_core_limp_if axi_fsm_limp ();

  letc_core_limp_arbiter #(.QUANTUM(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .icache_limp  (icache_limp),
    .dcache_limp  (dcache_limp),
    .axi_fsm_limp (axi_fsm_limp),
    .o_owner      (owner),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Downstream responder: read data is a fixed function of the address.
  assign axi_fsm_limp.rdata = axi_fsm_limp.addr + 32'hEFEF5678;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic req(input bit port, input logic [31:0] base, input int n,
                     input logic wen, input logic [31:0] wd);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      exp_t        e;
      int          waited;
      logic        rdy;
      a       = base + 32'(k * 4);
      e.addr  = a;
      e.rdata = a + 32'hEFEF5678;
      if (port) begin
        dcache_limp.valid = 1'b1; dcache_limp.addr = a;
        dcache_limp.wen_nren = wen; dcache_limp.wdata = wd;
        dq.push_back(e);
      end else begin
        icache_limp.valid = 1'b1; icache_limp.addr = a;
        icache_limp.wen_nren = wen; icache_limp.wdata = wd;
        iq.push_back(e);
      end
      waited = 0;
      rdy    = 1'b0;
      while (!rdy && waited < 100) begin
        @(negedge clk);
        waited++;
        rdy = port ? dcache_limp.ready : icache_limp.ready;
      end
      if (!rdy) chk(port ? "d_req_timeout" : "i_req_timeout", 32'(waited), 32'd0);
      @(posedge clk);
      #1;
    end
    if (port) dcache_limp.valid = 1'b0;
    else      icache_limp.valid = 1'b0;
  endtask

  task automatic idle_gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (axi_fsm_limp.valid && axi_fsm_limp.ready) begin
        if (owner_q.size() == 0) chk("owner_seq_unexpected", {31'd0, owner}, 32'hFFFFFFFF);
        else chk("owner_seq", {31'd0, owner}, {31'd0, owner_q.pop_front()});
      end
      if (icache_limp.valid && icache_limp.ready) begin
        if (iq.size() == 0) chk("i_unexpected_hs", icache_limp.addr, 32'hFFFFFFFF);
        else begin
          exp_t e;
          e = iq.pop_front();
          chk("i_down_addr", axi_fsm_limp.addr, e.addr);
          chk("i_rdata", icache_limp.rdata, e.rdata);
          chk("d_ready_nonowner", {31'd0, dcache_limp.ready}, 32'd0);
          chk("d_rdata_nonowner", dcache_limp.rdata, 32'd0);
        end
      end
      if (dcache_limp.valid && dcache_limp.ready) begin
        if (dq.size() == 0) chk("d_unexpected_hs", dcache_limp.addr, 32'hFFFFFFFF);
        else begin
          exp_t e;
          e = dq.pop_front();
          chk("d_down_addr", axi_fsm_limp.addr, e.addr);
          chk("d_rdata", dcache_limp.rdata, e.rdata);
          chk("i_ready_nonowner", {31'd0, icache_limp.ready}, 32'd0);
          chk("i_rdata_nonowner", icache_limp.rdata, 32'd0);
        end
      end
    end
  end

  a_ihold: assert property (@(posedge clk) disable iff (rst)
    (icache_limp.valid && !icache_limp.ready) |=>
      (icache_limp.valid && $stable(icache_limp.addr) && $stable(icache_limp.wdata)))
    else begin n_fail++; $display("FAIL icache_hold: requester changed before ready"); end

  a_dhold: assert property (@(posedge clk) disable iff (rst)
    (dcache_limp.valid && !dcache_limp.ready) |=>
      (dcache_limp.valid && $stable(dcache_limp.addr) && $stable(dcache_limp.wdata)))
    else begin n_fail++; $display("FAIL dcache_hold: requester changed before ready"); end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    icache_limp.valid = 1'b0; icache_limp.wen_nren = 1'b0; icache_limp.uncacheable = 1'b0;
    icache_limp.size = SIZE_WORD; icache_limp.addr = '0; icache_limp.wdata = '0;
    dcache_limp.valid = 1'b0; dcache_limp.wen_nren = 1'b0; dcache_limp.uncacheable = 1'b0;
    dcache_limp.size = SIZE_WORD; dcache_limp.addr = '0; dcache_limp.wdata = '0;
    axi_fsm_limp.ready = 1'b1;

    // Reset with both requesters valid; dcache wins first (prio resets to dcache)
    owner_q.push_back(1'b1);
    owner_q.push_back(1'b0);
    fork
      req(1'b1, 32'h20000040, 1, 1'b0, 32'd0);
      req(1'b0, 32'h00000100, 1, 1'b0, 32'd0);
      begin
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_axi_valid", {31'd0, axi_fsm_limp.valid}, 32'd0);
        chk("rst_i_ready",   {31'd0, icache_limp.ready}, 32'd0);
        chk("rst_d_ready",   {31'd0, dcache_limp.ready}, 32'd0);
        chk("rst_busy",      {31'd0, busy}, 32'd0);
        chk("rst_owner",     {31'd0, owner}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_busy",  {31'd0, busy}, 32'd1);
        chk("post_rst_owner", {31'd0, owner}, 32'd1);
        chk("post_rst_valid", {31'd0, axi_fsm_limp.valid}, 32'd1);
        chk("post_rst_addr",  axi_fsm_limp.addr, 32'h20000040);
      end
    join
    idle_gap();

    // Single icache read, one-cycle arbitration latency
    owner_q.push_back(1'b0);
    fork
      req(1'b0, 32'hABCD1234, 1, 1'b0, 32'd0);
      begin
        @(negedge clk);
        chk("single_lat_valid", {31'd0, axi_fsm_limp.valid}, 32'd0);
        chk("single_lat_ready", {31'd0, icache_limp.ready}, 32'd0);
        @(negedge clk);
        chk("single_valid", {31'd0, axi_fsm_limp.valid}, 32'd1);
        chk("single_ready", {31'd0, icache_limp.ready}, 32'd1);
        chk("single_rdata", icache_limp.rdata, 32'h9BBC68AC);
        chk("single_d_ready", {31'd0, dcache_limp.ready}, 32'd0);
      end
    join
    idle_gap();
    chk("single_prio", {31'd0, dut.prio}, 32'd1);

    // Quantum: dcache streams 8, icache waits -> D x4, I, D x4
    for (int k = 0; k < 4; k++) owner_q.push_back(1'b1);
    owner_q.push_back(1'b0);
    for (int k = 0; k < 4; k++) owner_q.push_back(1'b1);
    fork
      req(1'b1, 32'h11111110, 8, 1'b0, 32'd0);
      req(1'b0, 32'h00001000, 1, 1'b0, 32'd0);
    join
    idle_gap();

    // Idle owner keeps the bus: 10 back-to-back dcache reads, counter saturates
    for (int k = 0; k < 10; k++) owner_q.push_back(1'b1);
    fork
      req(1'b1, 32'h40000000, 10, 1'b0, 32'd0);
      begin
        @(negedge clk);
        chk("keep_lat_valid", {31'd0, axi_fsm_limp.valid}, 32'd0);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("keep_no_bubble", {31'd0, dcache_limp.ready}, 32'd1);
          chk("keep_owner", {31'd0, owner}, 32'd1);
        end
        @(negedge clk);
        chk("keep_cnt_sat", 32'(dut.cnt), 32'd4);
      end
    join
    idle_gap();

    // icache arrives in the same cycle as dcache's 4th handshake -> direct switch
    for (int k = 0; k < 4; k++) owner_q.push_back(1'b1);
    owner_q.push_back(1'b0);
    owner_q.push_back(1'b1);
    owner_q.push_back(1'b1);
    fork
      req(1'b1, 32'h50000000, 6, 1'b0, 32'd0);
      begin
        repeat (4) @(posedge clk);
        #1;
        req(1'b0, 32'h00003000, 1, 1'b0, 32'd0);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("simul_4th_owner", {31'd0, owner}, 32'd1);
        chk("simul_4th_dready", {31'd0, dcache_limp.ready}, 32'd1);
        chk("simul_i_waiting", {31'd0, icache_limp.ready}, 32'd0);
        @(negedge clk);
        chk("simul_busy", {31'd0, busy}, 32'd1);
        chk("simul_owner", {31'd0, owner}, 32'd0);
        chk("simul_iready", {31'd0, icache_limp.ready}, 32'd1);
      end
    join
    idle_gap();

    // Reset mid-transfer while icache holds a stalled write
    axi_fsm_limp.ready = 1'b0;
    owner_q.push_back(1'b0);
    fork
      req(1'b0, 32'h00002000, 1, 1'b1, 32'h3C3CA5A5);
      begin
        @(negedge clk);
        @(negedge clk);
        chk("midrst_owner", {31'd0, owner}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_valid", {31'd0, axi_fsm_limp.valid}, 32'd1);
        chk("midrst_wen", {31'd0, axi_fsm_limp.wen_nren}, 32'd1);
        chk("midrst_wdata", axi_fsm_limp.wdata, 32'h3C3CA5A5);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_after_valid", {31'd0, axi_fsm_limp.valid}, 32'd0);
        chk("midrst_after_busy", {31'd0, busy}, 32'd0);
        chk("midrst_after_prio", {31'd0, dut.prio}, 32'd1);
        chk("midrst_after_iready", {31'd0, icache_limp.ready}, 32'd0);
        rst = 1'b0;
        axi_fsm_limp.ready = 1'b1;
      end
    join
    idle_gap();

    repeat (5) @(posedge clk);
    chk("iq_drained", 32'(iq.size()), 32'd0);
    chk("dq_drained", 32'(dq.size()), 32'd0);
    chk("owner_q_drained", 32'(owner_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
